// File: rtl/data_mem_pipelined_pkg.sv
// Shared types and constants for the pipelined data memory.
package data_mem_pipelined_pkg;

    // Controller states: memory clear after reset, then normal request service.
    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    // Legal request-to-response latency range.
    localparam int unsigned READ_LAT_MIN = 1;
    localparam int unsigned READ_LAT_MAX = 3;

    // Number of byte-offset bits inside one word of data_w bits.
    function automatic int unsigned byte_off_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_bank_be.sv
// Single-port word array with byte-lane write enables and a registered read.
module mem_bank_be
    import data_mem_pipelined_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W/8-1:0]        be,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Byte-masked write and one-cycle registered read on the same port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/data_mem_pipelined.sv
// Word-addressed data memory with request/response handshake, power-up clear,
// address error detection and a configurable-latency response pipeline.
module data_mem_pipelined
    import data_mem_pipelined_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err
);

    localparam int unsigned OFF_W = byte_off_w(DATA_W);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    // Out-of-range latency values clamp to the legal range.
    localparam int unsigned LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                                  (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

    state_e            state_q;
    logic [IDX_W-1:0]  init_cnt_q;
    logic              ready_q;

    logic              accept;
    logic              misaligned;
    logic              out_of_range;
    logic              addr_err;
    logic [IDX_W-1:0]  word_idx;

    logic              mem_we;
    logic              mem_re;
    logic [IDX_W-1:0]  mem_addr;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              s0_valid_q;
    logic              s0_err_q;
    logic              s0_rd_q;
    logic [DATA_W-1:0] s0_data;

    assign req_ready = ready_q;

    // Controller: clear every word once after reset, then accept one request per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StInit;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // A request arriving with reset is dropped; its response could never be delivered anyway.
    assign accept       = req_valid & ready_q & ~reset;
    assign word_idx     = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign misaligned   = |req_addr[OFF_W-1:0];
    assign out_of_range = (req_addr >> (OFF_W + IDX_W)) != 32'd0;
    assign addr_err     = misaligned | out_of_range;

    // Memory port steering: clear engine during INIT, otherwise the accepted request.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = word_idx;
        mem_be    = req_be;
        mem_wdata = req_wdata;
        if (state_q == StInit) begin
            mem_we    = ~reset;
            mem_addr  = init_cnt_q;
            mem_be    = '1;
            mem_wdata = '0;
        end else if (accept && !addr_err) begin
            mem_we = req_write;
            mem_re = ~req_write;
        end
    end

    mem_bank_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .be    (mem_be),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Response attributes aligned with the memory read register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_err_q   <= 1'b0;
            s0_rd_q    <= 1'b0;
        end else begin
            s0_valid_q <= accept;
            s0_err_q   <= accept & addr_err;
            s0_rd_q    <= accept & ~req_write & ~addr_err;
        end
    end

    // Writes and errors answer with zero data; the bank output is only meaningful for reads.
    assign s0_data = s0_rd_q ? mem_rdata : '0;

    if (LAT == 1) begin : g_lat1
        assign rsp_valid = s0_valid_q;
        assign rsp_err   = s0_err_q;
        assign rsp_data  = s0_data;
    end else begin : g_pipe
        localparam int unsigned NSTG = LAT - 1;

        logic [NSTG-1:0]   valid_q;
        logic [NSTG-1:0]   err_q;
        logic [DATA_W-1:0] data_q [NSTG];

        // Extra delay stages; valid, err and data travel together and flush on reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= '0;
                err_q   <= '0;
                for (int k = 0; k < NSTG; k++) begin
                    data_q[k] <= '0;
                end
            end else begin
                valid_q[0] <= s0_valid_q;
                err_q[0]   <= s0_err_q;
                data_q[0]  <= s0_data;
                for (int k = 1; k < NSTG; k++) begin
                    valid_q[k] <= valid_q[k-1];
                    err_q[k]   <= err_q[k-1];
                    data_q[k]  <= data_q[k-1];
                end
            end
        end

        assign rsp_valid = valid_q[NSTG-1];
        assign rsp_err   = err_q[NSTG-1];
        assign rsp_data  = data_q[NSTG-1];
    end

endmodule

// File: tb/tb_data_mem_pipelined.sv
// Directed bench: three instances (latency 1, 2, 3) share one request stream.
module tb_data_mem_pipelined;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic [3:1]  rdy;
    logic [3:1]  vld;
    logic [3:1]  err;
    logic [31:0] dat1, dat2, dat3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_pipelined #(.DATA_W(32), .DEPTH(256), .READ_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld[1]), .rsp_data(dat1), .rsp_err(err[1])
    );
    data_mem_pipelined #(.DATA_W(32), .DEPTH(256), .READ_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld[2]), .rsp_data(dat2), .rsp_err(err[2])
    );
    data_mem_pipelined #(.DATA_W(32), .DEPTH(256), .READ_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[3]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld[3]), .rsp_data(dat3), .rsp_err(err[3])
    );

    function automatic logic [31:0] dat_of(input int j);
        return (j == 1) ? dat1 : (j == 2) ? dat2 : dat3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    // One isolated request; checks each instance pulses exactly once at its own latency.
    task automatic single(input string tag, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] exp_d, input logic exp_e);
        drive(wr, a, d, be);
        @(negedge clk);
        idle();
        for (int k = 1; k <= 4; k++) begin
            for (int j = 1; j <= 3; j++) begin
                if (k == j) begin
                    chk($sformatf("%s L%0d valid", tag, j), 32'(vld[j]), 32'd1);
                    chk($sformatf("%s L%0d data", tag, j), dat_of(j), exp_d);
                    chk($sformatf("%s L%0d err", tag, j), 32'(err[j]), 32'(exp_e));
                end else begin
                    chk($sformatf("%s L%0d idle c%0d", tag, j, k), 32'(vld[j]), 32'd0);
                end
            end
            if (k < 4) @(negedge clk);
        end
    endtask

    // Counts cycles with req_ready low after reset release; bounded.
    task automatic wait_init(input string tag);
        int   cnt;
        logic seen;
        cnt  = 0;
        seen = 1'b0;
        while (rdy[1] !== 1'b1 && cnt < 400) begin
            seen = seen | (|vld);
            cnt++;
            @(negedge clk);
        end
        chk({tag, " init cycles"}, 32'(cnt), 32'd256);
        chk({tag, " no rsp during init"}, 32'(seen), 32'd0);
        chk({tag, " ready all"}, 32'(rdy), 32'b111);
    endtask

    logic [31:0] model [8];
    logic [31:0] exp_d [64];
    int          rx [1:3];

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(rdy), 32'd0);
        chk("reset valid", 32'(vld), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset data1", dat1, 32'd0);
        chk("reset data3", dat3, 32'd0);
        reset = 1'b0;
        wait_init("first");

        single("rd 3fc", 1'b0, 32'h3FC, 32'h0, 4'h0, 32'h0, 1'b0);

        // Byte lanes
        single("wr full", 1'b1, 32'h10, 32'hAABBCCDD, 4'b1111, 32'h0, 1'b0);
        single("wr lanes", 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0);
        single("rd lanes", 1'b0, 32'h10, 32'h0, 4'h0, 32'hAA22CC44, 1'b0);
        single("wr be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        single("rd be0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hAA22CC44, 1'b0);

        // Errors
        single("rd 402", 1'b0, 32'h402, 32'h0, 4'h0, 32'h0, 1'b1);
        single("wr 400", 1'b1, 32'h400, 32'h5, 4'b1111, 32'h0, 1'b1);
        single("rd 0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        single("wr mis", 1'b1, 32'h11, 32'h12345678, 4'b1111, 32'h0, 1'b1);
        single("rd 10 after mis", 1'b0, 32'h10, 32'h0, 4'h0, 32'hAA22CC44, 1'b0);

        // Back-to-back write then read of the same word
        drive(1'b1, 32'h20, 32'hDEADBEEF, 4'b1111);
        @(negedge clk);
        chk("b2b L1 wr valid", 32'(vld[1]), 32'd1);
        chk("b2b L1 wr data", dat1, 32'd0);
        chk("b2b L3 c1", 32'(vld[3]), 32'd0);
        drive(1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        idle();
        chk("b2b L1 rd valid", 32'(vld[1]), 32'd1);
        chk("b2b L1 rd data", dat1, 32'hDEADBEEF);
        chk("b2b L2 wr valid", 32'(vld[2]), 32'd1);
        chk("b2b L3 c2", 32'(vld[3]), 32'd0);
        @(negedge clk);
        chk("b2b L2 rd data", dat2, 32'hDEADBEEF);
        chk("b2b L3 wr valid", 32'(vld[3]), 32'd1);
        chk("b2b L3 wr data", dat3, 32'd0);
        chk("b2b L3 wr err", 32'(err[3]), 32'd0);
        @(negedge clk);
        chk("b2b L3 rd valid", 32'(vld[3]), 32'd1);
        chk("b2b L3 rd data", dat3, 32'hDEADBEEF);
        chk("b2b L1 quiet", 32'(vld[1]), 32'd0);
        @(negedge clk);
        chk("b2b L3 done", 32'(vld[3]), 32'd0);

        // Streaming random traffic in words 64..71, untouched so far (all zero)
        for (int w = 0; w < 8; w++) model[w] = '0;
        for (int j = 1; j <= 3; j++) rx[j] = 0;
        for (int c = 0; c < 64 + 4; c++) begin
            for (int j = 1; j <= 3; j++) begin
                if (vld[j]) begin
                    if (rx[j] < 64) begin
                        chk($sformatf("stream L%0d #%0d data", j, rx[j]), dat_of(j),
                            exp_d[rx[j]]);
                        chk($sformatf("stream L%0d #%0d err", j, rx[j]), 32'(err[j]), 32'd0);
                    end else begin
                        chk($sformatf("stream L%0d extra", j), 32'(vld[j]), 32'd0);
                    end
                    rx[j]++;
                end
            end
            if (c < 64) begin
                logic        wr;
                int          w;
                logic [31:0] d;
                logic [3:0]  be;
                wr = 1'($urandom_range(0, 1));
                w  = int'($urandom_range(0, 7));
                d  = $urandom;
                be = 4'($urandom_range(0, 15));
                drive(wr, 32'h100 + 32'(w) * 4, d, be);
                if (wr) begin
                    exp_d[c] = '0;
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
                    end
                end else begin
                    exp_d[c] = model[w];
                end
            end else begin
                idle();
            end
            @(negedge clk);
        end
        for (int j = 1; j <= 3; j++) begin
            chk($sformatf("stream L%0d count", j), 32'(rx[j]), 32'd64);
        end

        // Reset with responses in flight
        drive(1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        drive(1'b0, 32'h14, 32'h0, 4'h0);
        reset = 1'b1;
        chk("rif L1 early rsp", 32'(vld[1]), 32'd1);
        @(negedge clk);
        idle();
        reset = 1'b0;
        chk("rif valid cleared", 32'(vld), 32'd0);
        chk("rif ready cleared", 32'(rdy), 32'd0);
        chk("rif data3 cleared", dat3, 32'd0);
        wait_init("after rif");
        single("rd 10 reinit", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
